sqrt_un: RTL
============

SQRT_UN -- requirements
Module: sqrt_un

Interface
REQ-001 SHALL have parameter WIDTH, default 32, radicand width; even, 8..64.
REQ-002 SHALL have parameter TAG_W, default 4, width of the pass-through sideband tag; 1..16.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  radicand offered.
REQ-006 SHALL have port in_ready  output  1  radicand accepted when in_valid & in_ready.
REQ-007 SHALL have port in_x  input  WIDTH  unsigned radicand.
REQ-008 SHALL have port in_rnd  input  1  per-transaction mode: 0 = floor, 1 = round-to-nearest.
REQ-009 SHALL have port in_tag  input  TAG_W  sideband, returned unchanged with the result.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  result consumed when out_valid & out_ready.
REQ-012 SHALL have port out_y  output  WIDTH/2  unsigned root.
REQ-013 SHALL have port out_tag  output  TAG_W  tag of the transaction in out_y.

Function
REQ-014 SHALL compute the root digit-by-digit (restoring), one result bit per pipeline stage, N = WIDTH/2 registered stages, MSB first.
REQ-015 SHALL provide stage k with partial remainder (WIDTH/2+2 bits), partial root, remaining radicand bits, in_rnd and tag, all registered.
REQ-016 SHALL use one global advance enable en = ~out_valid | out_ready; in_ready SHALL equal en combinationally.
REQ-017 SHALL shift every stage, including its valid bit, when en = 1, and hold all stages unchanged when en = 0.
REQ-018 SHALL present a transaction accepted at edge t on out_valid at edge t+N when no stall occurs; latency = N cycles, throughput 1 per cycle.
REQ-019 SHALL preserve transaction order; no loss or duplication under any out_ready pattern.
REQ-020 SHALL allow pipeline bubbles (in_valid = 0 while en = 1), which propagate as invalid stages.
REQ-021 SHALL in floor mode output out_y = floor(sqrt(in_x)).
REQ-022 SHALL in round mode output out_y = f + 1 when rem > f (f = floor root, rem = in_x - f*f), else f.
REQ-023 SHALL saturate the round-mode result at 2^(WIDTH/2)-1.
REQ-024 SHALL apply rounding inside the last stage, adding no latency.
REQ-025 SHALL hold out_y and out_tag stable while out_valid = 1 and out_ready = 0.

Reset
REQ-026 SHALL asynchronously clear every stage valid bit while rst_n = 0, giving out_valid = 0 and in_ready = 1.
REQ-027 SHALL not reset datapath registers; out_y and out_tag are don't-care while out_valid = 0.
REQ-028 SHALL discard all in-flight transactions on reset mid-operation; the first input after release SHALL produce a correct result after N cycles.

Configuration
REQ-029 SHALL, with SQRT_UN_REM_EN defined, add output port out_rem (WIDTH/2+1 bits) = in_x - f*f (floor remainder, independent of in_rnd), aligned with out_y.
REQ-030 SHALL, without SQRT_UN_REM_EN, have no out_rem port and no logic retaining the final remainder beyond what rounding needs.

Structure
REQ-031 SHALL place the WIDTH/TAG_W limits and a function computing remainder width from WIDTH in shared package sqrt_pkg.
REQ-032 SHALL implement one iteration as sub-module sqrt_un_step (parameters WIDTH, INDEX), instantiated N times via generate.

Verification
REQ-033 SHALL cover: WIDTH=32, in_x=0, floor -> out_y=0 (out_rem=0) exactly 16 cycles after acceptance.
REQ-034 SHALL cover: in_x=24 -> floor out_y=4, out_rem=8; round out_y=5; in_x=4294967295 floor -> 65535, out_rem=131070; round -> 65535 (saturated).
REQ-035 SHALL cover: 20 back-to-back inputs, tags 0..15 wrapping, out_ready low for 5 cycles mid-stream -> in_ready low during the stall, all 20 results in order with correct tags, none lost.
REQ-036 SHALL cover: rst_n pulsed low with 8 transactions in flight -> out_valid=0 immediately; no stale result after release; next input correct.
REQ-037 SHALL cover: WIDTH=8 exhaustive 0..255, both modes, random out_ready -> matches reference model (both macro settings).

Source files
------------

// File: rtl/sqrt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sqrt_pkg
// Description : Shared limits and width helpers for the pipelined unsigned
//               square-root unit (sqrt_un / sqrt_un_step).
// Revision    : 1.0 - initial release
// ============================================================================
package sqrt_pkg;

  // Supported radicand widths (must also be even)
  localparam int SQRT_WIDTH_MIN = 8;
  localparam int SQRT_WIDTH_MAX = 64;

  // Supported sideband tag widths
  localparam int SQRT_TAG_W_MIN = 1;
  localparam int SQRT_TAG_W_MAX = 16;

  // Partial remainder width: the final remainder needs WIDTH/2+1 bits and the
  // shifted-in digit pair needs one more before the trial subtraction.
  function automatic int sqrt_rem_width(input int width);
    return width / 2 + 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sqrt_un_step.sv
`default_nettype none
// ============================================================================
// Module      : sqrt_un_step
// Description : One restoring square-root iteration (combinational). Brings
//               down the next radicand digit pair, trial-subtracts
//               (root<<2)|1 and produces one root bit. The last instance
//               (INDEX == WIDTH/2-1) also applies round-to-nearest with
//               saturation when i_rnd is set.
// Revision    : 1.0 - initial release
// ============================================================================
module sqrt_un_step
  import sqrt_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int INDEX = 0
) (
  input  logic [sqrt_rem_width(WIDTH)-1:0] i_rem,
  input  logic [WIDTH/2-1:0]               i_root,
  input  logic [1:0]                       i_bits,
  input  logic                             i_rnd,
  output logic [sqrt_rem_width(WIDTH)-1:0] o_rem,
  output logic [WIDTH/2-1:0]               o_root
);

  localparam int N  = WIDTH / 2;
  localparam int RW = sqrt_rem_width(WIDTH);

  logic [RW-1:0] shifted;
  logic [RW-1:0] trial;
  logic [RW-1:0] diff;
  logic          take;
  logic [N-1:0]  floor_root;

  // Restoring iteration: keep the difference only when the trial fits
  always_comb begin
    shifted    = (i_rem << 2) | RW'(i_bits);
    trial      = {i_root, 2'b01};
    diff       = shifted - trial;
    take       = (shifted >= trial);
    o_rem      = take ? diff : shifted;
    floor_root = (i_root << 1) | N'(take);
  end

  if (INDEX == N - 1) begin : g_round
    logic round_up;
    // Round up when rem > f, unless f is already all-ones (saturate)
    always_comb begin
      round_up = i_rnd & (o_rem > RW'(floor_root)) & ~(&floor_root);
      o_root   = floor_root + N'(round_up);
    end
  end else begin : g_floor
    logic unused_rnd;
    assign unused_rnd = i_rnd;
    assign o_root     = floor_root;
  end

endmodule
`default_nettype wire

// File: rtl/sqrt_un.sv
`default_nettype none
// ============================================================================
// Module      : sqrt_un
// Description : Pipelined unsigned integer square root, one root bit per
//               registered stage (WIDTH/2 stages), valid/ready handshake with
//               a single global advance enable, pass-through tag and optional
//               floor/round-to-nearest mode per transaction.
//               Build option: define SQRT_UN_REM_EN to add out_rem (floor
//               remainder in_x - f*f).
// Revision    : 1.0 - initial release
// ============================================================================
module sqrt_un
  import sqrt_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_x,
  input  logic               in_rnd,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH/2-1:0] out_y,
  output logic [TAG_W-1:0]   out_tag
`ifdef SQRT_UN_REM_EN
  ,
  output logic [WIDTH/2:0]   out_rem
`endif
);

  localparam int N  = WIDTH / 2;
  localparam int RW = sqrt_rem_width(WIDTH);
  localparam int NI = N - 1;  // stages that feed another stage

  logic en;

  // Intermediate stage registers (stages 0 .. N-2)
  logic             valid_q [NI];
  logic             valid_d [NI];
  logic [RW-1:0]    rem_q   [NI];
  logic [RW-1:0]    rem_d   [NI];
  logic [N-1:0]     root_q  [NI];
  logic [N-1:0]     root_d  [NI];
  logic [WIDTH-1:0] x_q     [NI];
  logic [WIDTH-1:0] x_d     [NI];
  logic             rnd_q   [NI];
  logic             rnd_d   [NI];
  logic [TAG_W-1:0] tag_q   [NI];
  logic [TAG_W-1:0] tag_d   [NI];

  // Inputs seen by each iteration and their results
  logic             src_valid [N];
  logic [RW-1:0]    src_rem   [N];
  logic [N-1:0]     src_root  [N];
  logic [WIDTH-1:0] src_x     [N];
  logic             src_rnd   [N];
  logic [TAG_W-1:0] src_tag   [N];
  logic [RW-1:0]    step_rem  [N];
  logic [N-1:0]     step_root [N];

  // Output stage registers
  logic             out_valid_q, out_valid_d;
  logic [N-1:0]     y_q, y_d;
  logic [TAG_W-1:0] otag_q, otag_d;

  // Whole pipeline advances whenever the output slot is free or being drained
  assign en       = ~out_valid_q | out_ready;
  assign in_ready = en;

  // Stage k consumes the ports (k = 0) or the previous stage's registers
  always_comb begin
    src_valid[0] = in_valid;
    src_rem[0]   = '0;
    src_root[0]  = '0;
    src_x[0]     = in_x;
    src_rnd[0]   = in_rnd;
    src_tag[0]   = in_tag;
    for (int k = 1; k < N; k++) begin
      src_valid[k] = valid_q[k-1];
      src_rem[k]   = rem_q[k-1];
      src_root[k]  = root_q[k-1];
      src_x[k]     = x_q[k-1];
      src_rnd[k]   = rnd_q[k-1];
      src_tag[k]   = tag_q[k-1];
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_step
    sqrt_un_step #(
      .WIDTH (WIDTH),
      .INDEX (k)
    ) u_step (
      .i_rem  (src_rem[k]),
      .i_root (src_root[k]),
      .i_bits (src_x[k][WIDTH-1 -: 2]),
      .i_rnd  (src_rnd[k]),
      .o_rem  (step_rem[k]),
      .o_root (step_root[k])
    );
  end

  // Next state of the intermediate stages: shift on en, otherwise hold
  always_comb begin
    for (int k = 0; k < NI; k++) begin
      valid_d[k] = en ? src_valid[k]      : valid_q[k];
      rem_d[k]   = en ? step_rem[k]       : rem_q[k];
      root_d[k]  = en ? step_root[k]      : root_q[k];
      x_d[k]     = en ? (src_x[k] << 2)   : x_q[k];
      rnd_d[k]   = en ? src_rnd[k]        : rnd_q[k];
      tag_d[k]   = en ? src_tag[k]        : tag_q[k];
    end
  end

  // Next state of the output stage
  always_comb begin
    out_valid_d = en ? src_valid[N-1] : out_valid_q;
    y_d         = en ? step_root[N-1] : y_q;
    otag_d      = en ? src_tag[N-1]   : otag_q;
  end

  // Valid bits: the only state cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NI; k++) valid_q[k] <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      for (int k = 0; k < NI; k++) valid_q[k] <= valid_d[k];
      out_valid_q <= out_valid_d;
    end
  end

  // Datapath registers: no reset, qualified by the valid bits
  always_ff @(posedge clk) begin
    for (int k = 0; k < NI; k++) begin
      rem_q[k]  <= rem_d[k];
      root_q[k] <= root_d[k];
      x_q[k]    <= x_d[k];
      rnd_q[k]  <= rnd_d[k];
      tag_q[k]  <= tag_d[k];
    end
    y_q    <= y_d;
    otag_q <= otag_d;
  end

  assign out_valid = out_valid_q;
  assign out_y     = y_q;
  assign out_tag   = otag_q;

`ifdef SQRT_UN_REM_EN
  logic [N:0] orem_q, orem_d;
  logic       unused_rem_msb;

  assign unused_rem_msb = step_rem[N-1][RW-1];

  // Final floor remainder travels alongside out_y
  always_comb begin
    orem_d = en ? step_rem[N-1][N:0] : orem_q;
  end

  // Remainder output register
  always_ff @(posedge clk) begin
    orem_q <= orem_d;
  end

  assign out_rem = orem_q;
`else
  logic unused_last_rem;
  assign unused_last_rem = ^step_rem[N-1];
`endif

endmodule
`default_nettype wire
